// File: rtl/booth_mul32_pkg.sv
// Shared definitions for the iterative radix-2 Booth multiplier.
//   state_e    : FSM state encoding (idle / run / done)
//   BoothAdd   : {Q[0], q_1} pattern that adds the multiplicand
//   BoothSub   : {Q[0], q_1} pattern that subtracts the multiplicand
//   MulIter    : number of Booth iterations for a 32-bit operand
//   DataW      : operand width shared by the interface and datapath
package booth_mul32_pkg;

  localparam int unsigned DataW   = 32;
  localparam int unsigned MulIter = 32;

  localparam logic [1:0] BoothAdd = 2'b01;
  localparam logic [1:0] BoothSub = 2'b10;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/booth_mul32_if.sv
// Request/result bundle between the EX stage and the Booth multiplier.
//   start/cancel   : request and pipeline flush (master -> slave)
//   mcand/mplier   : signed operands, sampled on an accepted start
//   busy/done      : stall indication and one-cycle completion pulse
//   hi/lo          : 64-bit product {hi, lo}, held until the next completion
interface booth_mul32_if;
  import booth_mul32_pkg::*;

  logic             start;
  logic             cancel;
  logic [DataW-1:0] mcand;
  logic [DataW-1:0] mplier;
  logic             busy;
  logic             done;
  logic [DataW-1:0] hi;
  logic [DataW-1:0] lo;

  modport master (
    output start, cancel, mcand, mplier,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, cancel, mcand, mplier,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/booth_mul32_adder32.sv
// 32-bit adder/subtractor: s = a + (b ^ {32{m}}) + cin.
//   a, b  : operands
//   m     : invert b (set together with cin for subtraction)
//   cin   : carry in
//   s     : sum
//   of    : signed overflow
//   cf    : carry out
module booth_mul32_adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        m,
  input  logic        cin,
  output logic [31:0] s,
  output logic        of,
  output logic        cf
);

  logic [31:0] b_x;

  always_comb begin
    b_x       = b ^ {32{m}};
    {cf, s}   = {1'b0, a} + {1'b0, b_x} + {32'd0, cin};
    // Overflow when both addends share a sign that the sum does not.
    of        = (a[31] == b_x[31]) && (s[31] != a[31]);
  end

endmodule

// File: rtl/booth_mul32.sv
// Iterative 32x32 signed multiplier, radix-2 Booth, one iteration per cycle.
//   clk    : system clock
//   rst_n  : synchronous active-low reset
//   bus    : slave side of booth_mul32_if (start/cancel/operands in,
//            busy/done/hi/lo out)
// An accepted start is followed by 32 RUN cycles and one DONE cycle in which
// done pulses and {hi, lo} carries the product.
module booth_mul32
  import booth_mul32_pkg::*;
#(
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  booth_mul32_if.slave  bus
);

  state_e state_q, state_d;

  logic [W-1:0]     m_q, m_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     q_q, q_d;
  logic             q1_q, q1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     hi_q, hi_d;
  logic [W-1:0]     lo_q, lo_d;

  logic [1:0]   booth;
  logic         add_en;
  logic         sub_en;
  logic [W-1:0] sum;
  logic         of;
  logic         unused_cf;
  logic [W-1:0] sel_sum;
  logic         sign;
  logic [W-1:0] step_a;
  logic [W-1:0] step_q;
  logic         last_iter;

  // Booth decode and one iteration of the shift datapath.
  always_comb begin
    booth  = {q_q[0], q1_q};
    add_en = (booth == BoothAdd) || (booth == BoothSub);
    sub_en = (booth == BoothSub);
  end

  booth_mul32_adder32 u_adder (
    .a   (a_q),
    .b   (m_q),
    .m   (sub_en),
    .cin (sub_en),
    .s   (sum),
    .of  (of),
    .cf  (unused_cf)
  );

  always_comb begin
    sel_sum = add_en ? sum : a_q;
    // S[31]^OF recovers the true sign of the 33-bit result, which keeps
    // -2^31 operands correct when the add/sub overflows.
    sign    = add_en ? (sum[W-1] ^ of) : a_q[W-1];
    step_a  = {sign, sel_sum[W-1:1]};
    step_q  = {sel_sum[0], q_q[W-1:1]};
  end

  assign last_iter = (cnt_q == CNT_W'(MulIter - 1));

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StRun;
      StRun: begin
        if (bus.cancel)      state_d = StIdle;
        else if (last_iter)  state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs.
  always_comb begin
    bus.busy = (state_q == StRun) || (state_q == StDone);
    bus.done = (state_q == StDone);
    bus.hi   = hi_q;
    bus.lo   = lo_q;
  end

  // Datapath next state.
  always_comb begin
    m_d   = m_q;
    a_d   = a_q;
    q_d   = q_q;
    q1_d  = q1_q;
    cnt_d = cnt_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (state_q == StIdle && bus.start) begin
      m_d   = bus.mcand;
      a_d   = '0;
      q_d   = bus.mplier;
      q1_d  = 1'b0;
      cnt_d = '0;
    end else if (state_q == StRun && !bus.cancel) begin
      a_d   = step_a;
      q_d   = step_q;
      q1_d  = q_q[0];
      cnt_d = cnt_q + CNT_W'(1);
      // Product lands in hi/lo on the final step so it is valid with done.
      if (last_iter) begin
        hi_d = step_a;
        lo_d = step_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q   <= '0;
      a_q   <= '0;
      q_q   <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      m_q   <= m_d;
      a_q   <= a_d;
      q_q   <= q_d;
      q1_q  <= q1_d;
      cnt_q <= cnt_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
    end
  end

endmodule

// File: tb/tb_booth_mul32.sv
module tb_booth_mul32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  booth_mul32_if bus ();

  booth_mul32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Issues one operation and watches 40 cycles after the accepting edge.
  // A start pulse with new operands is replayed at cycle restart_at (0 = none).
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input int restart_at,
                       input bit with_cancel, output int done_cyc, output int busy_cyc,
                       output int done_cnt);
    bus.mcand  = a;
    bus.mplier = b;
    bus.start  = 1'b1;
    bus.cancel = with_cancel;
    tick();
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    done_cyc   = 0;
    busy_cyc   = 0;
    done_cnt   = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == restart_at) begin
        bus.mcand  = 32'h0000FFFF;
        bus.mplier = 32'h0000FFFF;
        bus.start  = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      tick();
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    n_cmp++;
    if (bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL reset_done: got %b want 0", bus.done);
    end
    n_cmp++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      n_err++;
      $display("FAIL reset_hilo: got %h want 0", {bus.hi, bus.lo});
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input int restart_at, input bit with_cancel,
                          input logic [63:0] want);
    int dc, bc, dn;
    do_op(a, b, restart_at, with_cancel, dc, bc, dn);
    n_cmp++;
    if (dc !== 33) begin
      n_err++;
      $display("FAIL %s_done_cycle: got %0d want 33", name, dc);
    end
    n_cmp++;
    if (bc !== 33) begin
      n_err++;
      $display("FAIL %s_busy_cycles: got %0d want 33", name, bc);
    end
    n_cmp++;
    if (dn !== 1) begin
      n_err++;
      $display("FAIL %s_done_pulses: got %0d want 1", name, dn);
    end
    n_cmp++;
    if ({bus.hi, bus.lo} !== want) begin
      n_err++;
      $display("FAIL %s_product: got %h want %h", name, {bus.hi, bus.lo}, want);
    end
  endtask

  task automatic test_basic;
    check_op("pos_3x5", 32'd3, 32'd5, 0, 1'b0, 64'h0000_0000_0000_000F);
    // Start during the DONE cycle must be ignored.
    check_op("neg_m7x6", 32'hFFFF_FFF9, 32'd6, 33, 1'b0, 64'hFFFF_FFFF_FFFF_FFD6);
    // Cancel together with start in IDLE: start wins.
    check_op("cancel_start", 32'd100, 32'hFFFF_FFFD, 0, 1'b1, 64'hFFFF_FFFF_FFFF_FED4);
  endtask

  task automatic test_boundary;
    check_op("min_x_min", 32'h8000_0000, 32'h8000_0000, 0, 1'b0, 64'h4000_0000_0000_0000);
    check_op("max_x_max", 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, 1'b0, 64'h3FFF_FFFF_0000_0001);
  endtask

  task automatic test_back_to_back;
    check_op("restart_ignored", 32'h10, 32'h20, 10, 1'b0, 64'h0000_0000_0000_0200);
  endtask

  task automatic test_mid_reset;
    bus.mcand  = 32'd1234;
    bus.mplier = 32'd5678;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 10; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_flags: got busy=%b done=%b want 0 0", bus.busy, bus.done);
    end
    n_cmp++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      n_err++;
      $display("FAIL midreset_hilo: got %h want 0", {bus.hi, bus.lo});
    end
    check_op("after_reset", 32'd100, 32'hFFFF_FFFD, 0, 1'b0, 64'hFFFF_FFFF_FFFF_FED4);
  endtask

  task automatic test_cancel;
    int dn;
    bus.mcand  = 32'd1234;
    bus.mplier = 32'd5678;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int c = 1; c < 20; c++) tick();
    bus.cancel = 1'b1;
    tick();
    bus.cancel = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b0) begin
      n_err++;
      $display("FAIL cancel_busy: got %b want 0", bus.busy);
    end
    dn = 0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) dn++;
      tick();
    end
    n_cmp++;
    if (dn !== 0) begin
      n_err++;
      $display("FAIL cancel_no_done: got %0d pulses want 0", dn);
    end
    n_cmp++;
    if ({bus.hi, bus.lo} !== 64'hFFFF_FFFF_FFFF_FED4) begin
      n_err++;
      $display("FAIL cancel_hilo_kept: got %h want fffffffffffffed4", {bus.hi, bus.lo});
    end
    check_op("after_cancel", 32'd1234, 32'd5678, 0, 1'b0, 64'h0000_0000_006A_E9BC);
  endtask

  initial begin
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    bus.mcand  = '0;
    bus.mplier = '0;
    test_reset();
    test_basic();
    test_boundary();
    test_back_to_back();
    test_mid_reset();
    test_cancel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
